// File: rtl/result_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_tx_pkg
// Description : Shared types and constants for the result UART transmitter.
//               The framer walks tx_state_t once per byte; each frame carries
//               FRAME_BYTES bytes of BITS_PER_BYTE data bits.
// Revision    : 1.0 - initial release
// ============================================================================
package result_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BYTES   = 5;
    localparam int BITS_PER_BYTE = 8;

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo
// Description : Synchronous FIFO holding result words for the UART framer.
//               Pointers carry one extra wrap bit so full and empty can be
//               told apart. Push and pop may occur on the same edge, also
//               while full (the pop frees the slot the push writes).
//               full/empty are flops that reflect occupancy after the edge.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               push, din  - write request and data
//               pop, dout  - read request and head-of-queue data (fall-through)
//               full, empty- registered occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic [c_ADDR_W:0] w_wr_ptr_next;
    logic [c_ADDR_W:0] w_rd_ptr_next;
    logic              r_full;
    logic              r_empty;
    logic              w_pop_ok;
    logic              w_push_ok;

    assign w_pop_ok  = pop & ~r_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted in that case.
    assign w_push_ok = push & (~r_full | w_pop_ok);

    assign w_wr_ptr_next = r_wr_ptr + {{c_ADDR_W{1'b0}}, w_push_ok};
    assign w_rd_ptr_next = r_rd_ptr + {{c_ADDR_W{1'b0}}, w_pop_ok};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_empty  <= (w_wr_ptr_next == w_rd_ptr_next);
            r_full   <= (w_wr_ptr_next[c_ADDR_W] != w_rd_ptr_next[c_ADDR_W]) &&
                        (w_wr_ptr_next[c_ADDR_W-1:0] == w_rd_ptr_next[c_ADDR_W-1:0]);
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : result_uart_tx
// Description : Buffers 32-bit core results and serialises each one as an
//               8N1 UART frame: SYNC_BYTE, then data[31:24] .. data[7:0].
//               Bytes go LSB first, back-to-back inside a frame; consecutive
//               frames are separated by one idle cycle.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               data_in     - result word to send
//               data_valid  - push request, sampled every rising edge
//               tx          - serial line, idle high, driven from a flop
//               busy        - frame in progress or words still queued
//               fifo_full   - FIFO holds FIFO_DEPTH words
//               drop_count  - pushes lost to a full FIFO, saturates at 255
// Revision    : 1.0 - initial release
// ============================================================================
module result_uart_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  drop_count
);

    import result_tx_pkg::*;

    localparam int                  c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          c_LAST_BIT  = 3'(BITS_PER_BYTE - 1);
    localparam logic [2:0]          c_LAST_BYTE = 3'(FRAME_BYTES - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [c_BAUD_W-1:0]  w_baud_next;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_next;
    logic [2:0]           r_byte_idx;
    logic [2:0]           w_byte_idx_next;
    logic [31:0]          r_word;
    logic [31:0]          w_word_next;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 r_busy;
    logic                 w_busy_next;
    logic [7:0]           r_drop;
    logic                 w_baud_done;
    logic                 w_pop;
    logic                 w_fifo_push;
    logic                 w_drop;
    logic [31:0]          w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    result_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_push),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_fifo_push = data_valid & (~w_fifo_full | w_pop);
    assign w_drop      = data_valid & w_fifo_full & ~w_pop;
    assign w_baud_done = (r_baud == c_BAUD_LAST);

    // r_word holds the data bytes still to be sent, next one in [31:24].
    // r_shift holds the byte on the wire; bit 0 is the next bit out.
    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = r_baud;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_word_next     = r_word;
        w_shift_next    = r_shift;
        w_tx_next       = r_tx;
        w_pop           = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_next   = 1'b1;
                w_baud_next = '0;
                if (!w_fifo_empty) begin
                    w_pop           = 1'b1;
                    w_state_next    = START;
                    w_word_next     = w_fifo_dout;
                    w_shift_next    = SYNC_BYTE;
                    w_byte_idx_next = 3'd0;
                    w_tx_next       = 1'b0;
                end
            end

            START: begin
                if (w_baud_done) begin
                    w_state_next   = DATA;
                    w_baud_next    = '0;
                    w_bit_idx_next = 3'd0;
                    w_tx_next      = r_shift[0];
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_tx_next      = r_shift[1];
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next    = START;
                        w_byte_idx_next = r_byte_idx + 3'd1;
                        w_shift_next    = r_word[31:24];
                        w_word_next     = {r_word[23:0], 8'h00};
                        w_tx_next       = 1'b0;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // Whenever the next state is IDLE no pop happens on this edge, so the
    // FIFO is non-empty afterwards exactly when it is non-empty now or a
    // push lands (a push into an empty FIFO is always accepted).
    assign w_busy_next = (w_state_next != IDLE) | ~w_fifo_empty | data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_word     <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_drop     <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_word     <= w_word_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_full  = w_fifo_full;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_uart_tx
// Description : Self-checking bench for result_uart_tx. A timing model of the
//               queue/framer predicts occupancy, drops and accepted words;
//               accepted words go to a scoreboard that a UART receiver on tx
//               drains frame by frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_uart_tx;

    localparam int         CPB       = 4;
    localparam int         DEPTH     = 8;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam int         FRAME_CYC = 50 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_valid;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  drop_count;

    result_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] sb[$];
    int          m_occ  = 0;
    int          m_tmr  = 0;
    int          m_drop = 0;
    bit          armed  = 1'b0;
    logic        m_pop;
    logic        m_acc;

    // A word leaves the queue when the framer is idle; a frame then occupies
    // FRAME_CYC edges before the framer is idle again.
    assign m_pop = (m_tmr == 0) && (m_occ != 0);
    assign m_acc = data_valid && ((m_occ < DEPTH) || m_pop);

    always @(posedge clk) begin
        if (rst) begin
            m_occ  <= 0;
            m_tmr  <= 0;
            m_drop <= 0;
            armed  <= 1'b1;
            sb.delete();
        end else begin
            m_occ <= m_occ + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_pop)          m_tmr <= FRAME_CYC;
            else if (m_tmr > 0) m_tmr <= m_tmr - 1;
            if (m_acc) sb.push_back(data_in);
            if (data_valid && !m_acc && (m_drop < 255)) m_drop <= m_drop + 1;
        end
    end

    // ---------------- per-cycle output invariants ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (armed && !rst) begin
                checks++;
                if (busy !== ((m_tmr != 0) || (m_occ != 0))) begin
                    errors++;
                    if (errors < 40) $display("FAIL inv_busy cyc %0d got %b exp %b", cyc, busy, ((m_tmr != 0) || (m_occ != 0)));
                end
                checks++;
                if (fifo_full !== (m_occ == DEPTH)) begin
                    errors++;
                    if (errors < 40) $display("FAIL inv_fifo_full cyc %0d got %b exp %b", cyc, fifo_full, (m_occ == DEPTH));
                end
                checks++;
                if (drop_count !== 8'(m_drop)) begin
                    errors++;
                    if (errors < 40) $display("FAIL inv_drop_count cyc %0d got %0d exp %0d", cyc, drop_count, m_drop);
                end
                if (m_tmr == 0) begin
                    checks++;
                    if (tx !== 1'b1) begin
                        errors++;
                        if (errors < 40) $display("FAIL inv_tx_idle cyc %0d got %b exp 1", cyc, tx);
                    end
                end
            end
        end
    end

    // ---------------- UART receiver / frame checker ----------------
    bit         mon_active  = 1'b0;
    int         mon_cnt     = 0;
    int         mon_nbytes  = 0;
    logic [7:0] mon_sh      = 8'h00;
    logic [7:0] mon_frame[5];
    logic [7:0] last_frame[5];
    int         frames_seen = 0;
    int         frame_start = 0;
    int         prev_start  = 0;

    initial begin
        logic [31:0] exp_word;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
                mon_nbytes = 0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    if (mon_nbytes == 0) begin
                        prev_start  = frame_start;
                        frame_start = cyc;
                    end
                end
            end else begin
                mon_cnt++;
                if ((mon_cnt >= CPB + 1) && (mon_cnt <= 8 * CPB + 1) && (((mon_cnt - 1) % CPB) == 0))
                    mon_sh = {tx, mon_sh[7:1]};
                if (mon_cnt == 9 * CPB + 1) begin
                    mon_active = 1'b0;
                    checks++;
                    if (tx !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit cyc %0d got %b exp 1", cyc, tx);
                    end
                    mon_frame[mon_nbytes] = mon_sh;
                    mon_nbytes++;
                    if (mon_nbytes == 5) begin
                        mon_nbytes = 0;
                        frames_seen++;
                        last_frame = mon_frame;
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL frame_unexpected got %h%h%h%h%h exp none", mon_frame[0], mon_frame[1], mon_frame[2], mon_frame[3], mon_frame[4]);
                        end else begin
                            exp_word = sb.pop_front();
                            if ({mon_frame[0], mon_frame[1], mon_frame[2], mon_frame[3], mon_frame[4]} !== {SYNC, exp_word}) begin
                                errors++;
                                $display("FAIL frame_data got %h%h%h%h%h exp %h%h", mon_frame[0], mon_frame[1], mon_frame[2], mon_frame[3], mon_frame[4], SYNC, exp_word);
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (((busy !== 1'b0) || (sb.size() != 0)) && (n < bound)) begin
            step();
            n++;
        end
        checks++;
        if ((busy !== 1'b0) || (sb.size() != 0)) begin
            errors++;
            $display("FAIL drain_timeout busy %b pending %0d exp busy 0 pending 0", busy, sb.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        step();
        checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (fifo_full !== 1'b0)  begin errors++; $display("FAIL reset_fifo_full got %b exp 0", fifo_full); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        int f0;
        do_reset();
        f0         = frames_seen;
        data_in    = 32'h1234ABCD;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL latency_tx_accept_edge got %b exp 1", tx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy got %b exp 1", busy); end
        step();
        checks++; if (tx !== 1'b0)   begin errors++; $display("FAIL latency_tx_fall got %b exp 0", tx); end
        n = 0;
        while ((busy !== 1'b0) && (n < 1000)) begin
            step();
            n++;
        end
        checks++; if (n != FRAME_CYC) begin errors++; $display("FAIL frame_length got %0d exp %0d", n, FRAME_CYC); end
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL tx_after_frame got %b exp 1", tx); end
        checks++;
        if ((frames_seen - f0 != 1) ||
            ({last_frame[0], last_frame[1], last_frame[2], last_frame[3], last_frame[4]} !== 40'hA5_12_34_AB_CD)) begin
            errors++;
            $display("FAIL single_bytes got %h%h%h%h%h (%0d frames) exp a51234abcd", last_frame[0], last_frame[1], last_frame[2], last_frame[3], last_frame[4], frames_seen - f0);
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        do_reset();
        f0         = frames_seen;
        data_valid = 1'b1;
        data_in    = 32'h00000001;
        step();
        data_in    = 32'hFFFFFFFF;
        step();
        data_valid = 1'b0;
        wait_drain(2000);
        checks++; if (frames_seen - f0 != 2) begin errors++; $display("FAIL b2b_frames got %0d exp 2", frames_seen - f0); end
        checks++; if (frame_start - prev_start != FRAME_CYC + 1) begin errors++; $display("FAIL b2b_gap got %0d exp %0d", frame_start - prev_start, FRAME_CYC + 1); end
        checks++;
        if ({last_frame[0], last_frame[1], last_frame[2], last_frame[3], last_frame[4]} !== 40'hA5_FF_FF_FF_FF) begin
            errors++;
            $display("FAIL b2b_second got %h%h%h%h%h exp a5ffffffff", last_frame[0], last_frame[1], last_frame[2], last_frame[3], last_frame[4]);
        end
    endtask

    task automatic test_overflow();
        int f0;
        do_reset();
        f0 = frames_seen;
        for (int i = 0; i < 10; i++) begin
            data_valid = 1'b1;
            data_in    = 32'hC0DE_0000 + i;
            step();
        end
        data_valid = 1'b0;
        checks++; if (fifo_full !== 1'b1)  begin errors++; $display("FAIL overflow_full got %b exp 1", fifo_full); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL overflow_drop got %0d exp 1", drop_count); end
        wait_drain(5000);
        checks++; if (frames_seen - f0 != 9) begin errors++; $display("FAIL overflow_frames got %0d exp 9", frames_seen - f0); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            data_valid = 1'b1;
            data_in    = $urandom;
            step();
        end
        data_valid = 1'b0;
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d exp 255", drop_count); end
        do_reset();
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int f0;
        do_reset();
        data_in    = 32'hDEADBEEF;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        n = 0;
        while ((tx !== 1'b0) && (n < 20)) begin
            step();
            n++;
        end
        // Land in the data bits of the second byte.
        repeat (10 * CPB + 3 * CPB) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL midreset_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL midreset_drop got %0d exp 0", drop_count); end
        f0         = frames_seen;
        data_in    = 32'h0F0F5A5A;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        wait_drain(2000);
        checks++;
        if ((frames_seen - f0 != 1) ||
            ({last_frame[0], last_frame[1], last_frame[2], last_frame[3], last_frame[4]} !== 40'hA5_0F_0F_5A_5A)) begin
            errors++;
            $display("FAIL midreset_clean_frame got %h%h%h%h%h (%0d frames) exp a50f0f5a5a", last_frame[0], last_frame[1], last_frame[2], last_frame[3], last_frame[4], frames_seen - f0);
        end
    endtask

    task automatic test_push_pop_full();
        bit found = 1'b0;
        bit pop_now;
        int drop_before;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            data_valid = 1'b1;
            data_in    = 32'hB0B0_0000 + i;
            step();
        end
        for (int i = 0; (i < 400) && !found; i++) begin
            data_valid  = 1'b1;
            data_in     = 32'h5EED_0000 + i;
            pop_now     = m_pop;
            drop_before = m_drop;
            step();
            if (pop_now) begin
                found = 1'b1;
                checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pushpop_full got %b exp 1", fifo_full); end
                checks++; if (drop_count !== 8'(drop_before)) begin errors++; $display("FAIL pushpop_drop got %0d exp %0d", drop_count, drop_before); end
            end
        end
        data_valid = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL pushpop_no_pop got 0 exp 1"); end
        wait_drain(5000);
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 32'h0;
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_saturate();
        test_reset_mid_frame();
        test_push_pop_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
